// File: rtl/ram_rdata_return.sv
// ram_rdata_return: read-data return path of the RAM arbitration fabric.
// It re-arbitrates the requester prefixes with the forward mux's fixed
// priority (port 0 highest) and carries a {valid, code} tag per requester
// through RD_LAT stages. When a tag reaches the last stage, the data from the
// matching RAM port is registered onto rdataN and rvalidN pulses for one
// cycle. Ports that lose a RAM to a lower-index port are flagged on collideN,
// and the total number of losses is added to the saturating collide_cnt.
module ram_rdata_return #(
   parameter int DW     = 64,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    prefix0,
   input  logic [2:0]    prefix1,
   input  logic [2:0]    prefix2,
   input  logic [2:0]    prefix3,
   input  logic          we0,
   input  logic          we1,
   input  logic          we2,
   input  logic          we3,
   input  logic          req0,
   input  logic          req1,
   input  logic          req2,
   input  logic          req3,
   input  logic [DW-1:0] dout_448ramr,
   input  logic [DW-1:0] dout_64rama0,
   input  logic [DW-1:0] dout_64rama1,
   input  logic [DW-1:0] dout_64ramb0,
   input  logic [DW-1:0] dout_64ramb1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [DW-1:0] rdata2,
   output logic [DW-1:0] rdata3,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic          rvalid2,
   output logic          rvalid3,
   output logic          collide0,
   output logic          collide1,
   output logic          collide2,
   output logic          collide3,
   output logic [15:0]   collide_cnt
);

   localparam int NP = 4;

   logic [2:0]    code_p0   [NP];
   logic          we_p0     [NP];
   logic          req_p0    [NP];
   logic          lose_p0   [NP];
   logic          rd_vld_p0 [NP];
   logic [1:0]    n_lose_p0;

   logic          tag_vld_p1  [NP][RD_LAT];
   logic [2:0]    tag_code_p1 [NP][RD_LAT];
   logic [DW-1:0] ret_data_p1 [NP];

   logic [DW-1:0] rdata_p2   [NP];
   logic          rvalid_p2  [NP];
   logic          collide_p1 [NP];
   logic [15:0]   cnt_p1;

   // Counter increment that pins at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add(input logic [15:0] acc,
                                           input logic [1:0]  inc);
      logic [16:0] sum;
      sum = {1'b0, acc} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   assign code_p0[0] = prefix0;
   assign code_p0[1] = prefix1;
   assign code_p0[2] = prefix2;
   assign code_p0[3] = prefix3;
   assign we_p0[0]   = we0;
   assign we_p0[1]   = we1;
   assign we_p0[2]   = we2;
   assign we_p0[3]   = we3;
   assign req_p0[0]  = req0;
   assign req_p0[1]  = req1;
   assign req_p0[2]  = req2;
   assign req_p0[3]  = req3;

   // ---- stage p0: arbitration and read qualification on live inputs ----
   // Prefix-only priority, so a write or idle strobe still blocks higher ports.
   always_comb begin
      n_lose_p0 = 2'd0;
      for (int n = 0; n < NP; n++) begin
         lose_p0[n] = 1'b0;
         for (int j = 0; j < NP; j++) begin
            if (j < n && code_p0[j] == code_p0[n]) lose_p0[n] = 1'b1;
         end
         lose_p0[n]   = lose_p0[n] && (code_p0[n] != 3'b000);
         rd_vld_p0[n] = req_p0[n] && (code_p0[n] != 3'b000) && !lose_p0[n] &&
                        (code_p0[n] == 3'b001 || (code_p0[n][1] && !we_p0[n]));
         n_lose_p0    = n_lose_p0 + {1'b0, lose_p0[n]};
      end
   end

   // ---- stage p1: tag pipeline matched to RAM read latency ----
   // Valid bits are cleared on reset so in-flight reads never return.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NP; n++)
            for (int s = 0; s < RD_LAT; s++)
               tag_vld_p1[n][s] <= 1'b0;
      end else begin
         for (int n = 0; n < NP; n++) begin
            tag_vld_p1[n][0] <= rd_vld_p0[n];
            for (int s = 1; s < RD_LAT; s++)
               tag_vld_p1[n][s] <= tag_vld_p1[n][s-1];
         end
      end
   end

   // Tag codes only steer the data mux; they are meaningful only under a valid bit.
   always_ff @(posedge clk) begin
      for (int n = 0; n < NP; n++) begin
         tag_code_p1[n][0] <= code_p0[n];
         for (int s = 1; s < RD_LAT; s++)
            tag_code_p1[n][s] <= tag_code_p1[n][s-1];
      end
   end

   // Select the RAM output addressed by the tag in the final stage.
   always_comb begin
      for (int n = 0; n < NP; n++) begin
         ret_data_p1[n] = '0;
         case (tag_code_p1[n][RD_LAT-1])
            3'b001:  ret_data_p1[n] = dout_448ramr;
            3'b010:  ret_data_p1[n] = dout_64rama0;
            3'b110:  ret_data_p1[n] = dout_64rama1;
            3'b011:  ret_data_p1[n] = dout_64ramb0;
            3'b111:  ret_data_p1[n] = dout_64ramb1;
            default: ret_data_p1[n] = '0;
         endcase
      end
   end

   // ---- stage p2: registered return data, valid pulse and collision status ----
   // rdata only loads on a returning read and otherwise keeps its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NP; n++) begin
            rdata_p2[n]   <= '0;
            rvalid_p2[n]  <= 1'b0;
            collide_p1[n] <= 1'b0;
         end
         cnt_p1 <= 16'd0;
      end else begin
         for (int n = 0; n < NP; n++) begin
            rvalid_p2[n]  <= tag_vld_p1[n][RD_LAT-1];
            collide_p1[n] <= lose_p0[n];
            if (tag_vld_p1[n][RD_LAT-1]) rdata_p2[n] <= ret_data_p1[n];
         end
         cnt_p1 <= sat_add(cnt_p1, n_lose_p0);
      end
   end

   assign rdata0      = rdata_p2[0];
   assign rdata1      = rdata_p2[1];
   assign rdata2      = rdata_p2[2];
   assign rdata3      = rdata_p2[3];
   assign rvalid0     = rvalid_p2[0];
   assign rvalid1     = rvalid_p2[1];
   assign rvalid2     = rvalid_p2[2];
   assign rvalid3     = rvalid_p2[3];
   assign collide0    = collide_p1[0];
   assign collide1    = collide_p1[1];
   assign collide2    = collide_p1[2];
   assign collide3    = collide_p1[3];
   assign collide_cnt = cnt_p1;

endmodule

// File: tb/tb_ram_rdata_return.sv
// Testbench for ram_rdata_return: four instances with RD_LAT = 1..4 share one
// stimulus stream; a cycle-indexed reference model predicts every output.
`timescale 1ns/1ps
module tb_ram_rdata_return;
   localparam int DW = 64;
   localparam int NI = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    prefix [4];
   logic          we     [4];
   logic          req    [4];
   logic [DW-1:0] dout   [5];   // 0:448r 1:a0 2:a1 3:b0 4:b1

   logic          rv  [NI][4];
   logic [DW-1:0] rd  [NI][4];
   logic          col [NI][4];
   logic [15:0]   cnt [NI];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // input history ring, one entry per cycle
   logic          h_rst  [8];
   logic [2:0]    h_pre  [8][4];
   logic          h_we   [8][4];
   logic          h_req  [8][4];
   logic [DW-1:0] h_dout [8][5];

   // model expectations for the current cycle
   logic [3:0]    exp_rv [NI];
   logic [DW-1:0] exp_rd [NI][4];
   logic [3:0]    exp_col;
   int            exp_cnt;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ram_rdata_return #(.DW(DW), .RD_LAT(g + 1)) u_dut (
         .clk(clk), .rst(rst),
         .prefix0(prefix[0]), .prefix1(prefix[1]), .prefix2(prefix[2]), .prefix3(prefix[3]),
         .we0(we[0]), .we1(we[1]), .we2(we[2]), .we3(we[3]),
         .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
         .dout_448ramr(dout[0]), .dout_64rama0(dout[1]), .dout_64rama1(dout[2]),
         .dout_64ramb0(dout[3]), .dout_64ramb1(dout[4]),
         .rdata0(rd[g][0]), .rdata1(rd[g][1]), .rdata2(rd[g][2]), .rdata3(rd[g][3]),
         .rvalid0(rv[g][0]), .rvalid1(rv[g][1]), .rvalid2(rv[g][2]), .rvalid3(rv[g][3]),
         .collide0(col[g][0]), .collide1(col[g][1]), .collide2(col[g][2]), .collide3(col[g][3]),
         .collide_cnt(cnt[g])
      );
   end

   function automatic logic [3:0] pack_rv(input int g);
      return {rv[g][3], rv[g][2], rv[g][1], rv[g][0]};
   endfunction

   function automatic logic [3:0] pack_col(input int g);
      return {col[g][3], col[g][2], col[g][1], col[g][0]};
   endfunction

   function automatic int code_idx(input logic [2:0] c);
      case (c)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b110:  return 2;
         3'b011:  return 3;
         3'b111:  return 4;
         default: return 0;
      endcase
   endfunction

   // Read rule: strobe set, first port holding this RAM code, and a read code.
   function automatic bit is_read(input int s, input int n);
      logic [2:0] c;
      c = h_pre[s][n];
      if (!h_req[s][n] || c == 3'b000) return 1'b0;
      for (int j = 0; j < n; j++) if (h_pre[s][j] == c) return 1'b0;
      if (c == 3'b001) return 1'b1;
      if (c == 3'b010 || c == 3'b110 || c == 3'b011 || c == 3'b111) return !h_we[s][n];
      return 1'b0;
   endfunction

   // Record this cycle's inputs, clock once, and predict the next cycle.
   task automatic step();
      int  s, c, rs, lat, losses;
      bit  v;
      c = cyc;
      s = c % 8;
      h_rst[s] = rst;
      for (int n = 0; n < 4; n++) begin
         h_pre[s][n] = prefix[n];
         h_we[s][n]  = we[n];
         h_req[s][n] = req[n];
      end
      for (int d = 0; d < 5; d++) h_dout[s][d] = dout[d];
      @(posedge clk);
      #1;
      if (h_rst[s]) begin
         exp_col = 4'b0;
         exp_cnt = 0;
      end else begin
         losses = 0;
         for (int n = 0; n < 4; n++) begin
            exp_col[n] = 1'b0;
            for (int j = 0; j < n; j++)
               if (h_pre[s][n] != 3'b000 && h_pre[s][j] == h_pre[s][n]) exp_col[n] = 1'b1;
            if (exp_col[n]) losses++;
         end
         exp_cnt = exp_cnt + losses;
         if (exp_cnt > 65535) exp_cnt = 65535;
      end
      for (int g = 0; g < NI; g++) begin
         lat = g + 1;
         for (int n = 0; n < 4; n++) begin
            v  = 1'b0;
            rs = 0;
            if (c - lat >= 0) begin
               rs = (c - lat) % 8;
               v  = is_read(rs, n);
               for (int k = c - lat; k <= c; k++) if (h_rst[k % 8]) v = 1'b0;
            end
            if (h_rst[s]) begin
               exp_rv[g][n] = 1'b0;
               exp_rd[g][n] = '0;
            end else begin
               exp_rv[g][n] = v;
               if (v) exp_rd[g][n] = h_dout[s][code_idx(h_pre[rs][n])];
            end
         end
      end
      cyc = c + 1;
   endtask

   task automatic idle();
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         prefix[n] = 3'b000;
         we[n]     = 1'b0;
         req[n]    = 1'b0;
      end
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      for (int n = 0; n < 4; n++) prefix[n] = 3'b011;
      step();
      step();
      for (int g = 0; g < NI; g++) begin
         compared++;
         if (pack_rv(g) !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_rvalid inst%0d: got %b want 0000", g, pack_rv(g));
         end
         compared++;
         if (pack_col(g) !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_collide inst%0d: got %b want 0000", g, pack_col(g));
         end
         compared++;
         if (cnt[g] !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_cnt inst%0d: got %h want 0000", g, cnt[g]);
         end
         for (int n = 0; n < 4; n++) begin
            compared++;
            if (rd[g][n] !== '0) begin
               mismatched++;
               $display("FAIL reset_rdata inst%0d port%0d: got %h want 0", g, n, rd[g][n]);
            end
         end
      end
      idle();
      step();
   endtask

   task automatic test_single_read();
      drain();
      prefix[0] = 3'b001;
      req[0]    = 1'b1;
      step();
      idle();
      dout[0] = 64'hA5A5;
      step();
      compared++;
      if (pack_rv(0) !== 4'b0001 || rd[0][0] !== 64'hA5A5) begin
         mismatched++;
         $display("FAIL single_read: got rvalid %b rdata0 %h want 0001 000000000000a5a5",
                  pack_rv(0), rd[0][0]);
      end
      dout[0] = 64'h1234;
      step();
      compared++;
      if (pack_rv(0) !== 4'b0000 || rd[0][0] !== 64'hA5A5) begin
         mismatched++;
         $display("FAIL single_pulse: got rvalid %b rdata0 %h want 0000 000000000000a5a5",
                  pack_rv(0), rd[0][0]);
      end
   endtask

   task automatic test_four_ports();
      drain();
      prefix[0] = 3'b001; prefix[1] = 3'b010; prefix[2] = 3'b111; prefix[3] = 3'b110;
      for (int n = 0; n < 4; n++) req[n] = 1'b1;
      dout[0] = 64'h1111_0000_0000_0448;
      dout[1] = 64'h2222_0000_0000_00A0;
      dout[2] = 64'h3333_0000_0000_00A1;
      dout[3] = 64'h4444_0000_0000_00B0;
      dout[4] = 64'h5555_0000_0000_00B1;
      step();
      idle();
      step();
      step();
      compared++;
      if (pack_rv(2) !== 4'b0000) begin
         mismatched++;
         $display("FAIL four_early: got rvalid %b want 0000", pack_rv(2));
      end
      step();
      compared++;
      if (pack_rv(2) !== 4'b1111) begin
         mismatched++;
         $display("FAIL four_rvalid: got %b want 1111", pack_rv(2));
      end
      compared++;
      if (rd[2][0] !== 64'h1111_0000_0000_0448 || rd[2][1] !== 64'h2222_0000_0000_00A0 ||
          rd[2][2] !== 64'h5555_0000_0000_00B1 || rd[2][3] !== 64'h3333_0000_0000_00A1) begin
         mismatched++;
         $display("FAIL four_rdata: got %h %h %h %h", rd[2][0], rd[2][1], rd[2][2], rd[2][3]);
      end
      step();
      compared++;
      if (pack_rv(2) !== 4'b0000) begin
         mismatched++;
         $display("FAIL four_pulse: got %b want 0000", pack_rv(2));
      end
   endtask

   task automatic test_collision();
      int saved;
      drain();
      saved = exp_cnt;
      prefix[1] = 3'b011; prefix[3] = 3'b011;
      req[1] = 1'b1; req[3] = 1'b1;
      step();
      for (int g = 0; g < NI; g++) begin
         compared++;
         if (pack_col(g) !== 4'b1000 || cnt[g] !== 16'(saved + 1)) begin
            mismatched++;
            $display("FAIL collide_flag inst%0d: got %b cnt %h want 1000 cnt %h",
                     g, pack_col(g), cnt[g], 16'(saved + 1));
         end
      end
      idle();
      dout[3] = 64'hBEEF_0003;
      step();
      compared++;
      if (pack_col(0) !== 4'b0000 || pack_rv(0) !== 4'b0010 || rd[0][1] !== 64'hBEEF_0003) begin
         mismatched++;
         $display("FAIL collide_return: got col %b rv %b rd1 %h want 0000 0010 beef0003",
                  pack_col(0), pack_rv(0), rd[0][1]);
      end
   endtask

   task automatic test_writes();
      drain();
      prefix[0] = 3'b101; req[0] = 1'b1;
      prefix[2] = 3'b010; we[2]  = 1'b1; req[2] = 1'b1;
      step();
      idle();
      for (int i = 0; i < 5; i++) begin
         for (int g = 0; g < NI; g++) begin
            compared++;
            if (pack_rv(g) !== 4'b0000 || pack_col(g) !== 4'b0000) begin
               mismatched++;
               $display("FAIL writes_silent t%0d inst%0d: got rv %b col %b want 0000 0000",
                        i, g, pack_rv(g), pack_col(g));
            end
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      bit want;
      drain();
      for (int k = 0; k <= 8; k++) begin
         idle();
         if (k <= 4) begin
            prefix[0] = 3'b001;
            req[0]    = 1'b1;
         end
         rst     = (k == 2);
         dout[0] = 64'h100 + 64'(k);
         step();
         want = (k + 1 == 6) || (k + 1 == 7);
         compared++;
         if (rv[1][0] !== want) begin
            mismatched++;
            $display("FAIL reset_mid_rvalid cycle%0d: got %b want %b", k + 1, rv[1][0], want);
         end
         if (want) begin
            compared++;
            if (rd[1][0] !== 64'h100 + 64'(k)) begin
               mismatched++;
               $display("FAIL reset_mid_rdata cycle%0d: got %h want %h", k + 1, rd[1][0],
                        64'h100 + 64'(k));
            end
         end
      end
      compared++;
      if (cnt[1] !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_mid_cnt: got %h want 0000", cnt[1]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         for (int n = 0; n < 4; n++) begin
            prefix[n] = 3'($urandom_range(0, 7));
            we[n]     = 1'($urandom_range(0, 1));
            req[n]    = ($urandom_range(0, 3) != 0);
         end
         for (int d = 0; d < 5; d++) dout[d] = {$urandom, $urandom};
         step();
         for (int g = 0; g < NI; g++) begin
            compared++;
            if (pack_rv(g) !== exp_rv[g]) begin
               mismatched++;
               $display("FAIL rand_rvalid c%0d inst%0d: got %b want %b", cyc, g, pack_rv(g), exp_rv[g]);
            end
            for (int n = 0; n < 4; n++) begin
               compared++;
               if (rd[g][n] !== exp_rd[g][n]) begin
                  mismatched++;
                  $display("FAIL rand_rdata c%0d inst%0d port%0d: got %h want %h",
                           cyc, g, n, rd[g][n], exp_rd[g][n]);
               end
            end
            compared++;
            if (pack_col(g) !== exp_col) begin
               mismatched++;
               $display("FAIL rand_collide c%0d inst%0d: got %b want %b", cyc, g, pack_col(g), exp_col);
            end
            compared++;
            if (cnt[g] !== exp_cnt[15:0]) begin
               mismatched++;
               $display("FAIL rand_cnt c%0d inst%0d: got %h want %h", cyc, g, cnt[g], exp_cnt[15:0]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      idle();
      rst = 1'b1;
      step();
      idle();
      for (int n = 0; n < 4; n++) prefix[n] = 3'b101;
      for (int i = 0; i < 21844; i++) step();
      prefix[3] = 3'b000;
      step();
      for (int g = 0; g < NI; g++) begin
         compared++;
         if (cnt[g] !== 16'hFFFE) begin
            mismatched++;
            $display("FAIL sat_preload inst%0d: got %h want fffe", g, cnt[g]);
         end
      end
      step();
      for (int g = 0; g < NI; g++) begin
         compared++;
         if (cnt[g] !== 16'hFFFF || pack_col(g) !== 4'b0110) begin
            mismatched++;
            $display("FAIL sat_reach inst%0d: got %h col %b want ffff 0110", g, cnt[g], pack_col(g));
         end
      end
      prefix[3] = 3'b101;
      for (int i = 0; i < 2; i++) begin
         step();
         for (int g = 0; g < NI; g++) begin
            compared++;
            if (cnt[g] !== 16'hFFFF || pack_col(g) !== 4'b1110) begin
               mismatched++;
               $display("FAIL sat_hold t%0d inst%0d: got %h col %b want ffff 1110",
                        i, g, cnt[g], pack_col(g));
            end
         end
      end
      idle();
   endtask

   initial begin
      for (int s = 0; s < 8; s++) h_rst[s] = 1'b1;
      for (int d = 0; d < 5; d++) dout[d] = '0;
      for (int g = 0; g < NI; g++) begin
         exp_rv[g] = 4'b0;
         for (int n = 0; n < 4; n++) exp_rd[g][n] = '0;
      end
      exp_col = 4'b0;
      exp_cnt = 0;
      idle();
      rst = 1'b1;
      test_reset();
      test_single_read();
      test_four_ports();
      test_collision();
      test_writes();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
